// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: PC increment, default
// reset/exception addresses and the next-PC select encoding.
package mips_pkg;

  localparam int unsigned PC_INCR            = 4;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_BR   = 3'd1,
    NPC_J    = 3'd2,
    NPC_JR   = 3'd3,
    NPC_EXC  = 3'd4,
    NPC_HOLD = 3'd5
  } npc_sel_e;

  // Redirect priority: Exception > Stall > JumpReg > Jump > BranchTaken > sequential.
  function automatic npc_sel_e npc_select(input logic exc, input logic stall,
                                          input logic jr, input logic j,
                                          input logic br);
    if (exc)        return NPC_EXC;
    else if (stall) return NPC_HOLD;
    else if (jr)    return NPC_JR;
    else if (j)     return NPC_J;
    else if (br)    return NPC_BR;
    else            return NPC_SEQ;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; a pop on an empty stack does nothing.
module pc_ras
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] entries_q [RAS_DEPTH];
  logic [WIDTH-1:0] entries_d [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc;
  logic [CW-1:0]    count_q, count_d;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(RAS_DEPTH));
  assign top     = empty ? '0 : entries_q[ptr_q];
  assign ptr_inc = ptr_q + 1'b1;

  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    if (push && pop) begin
      // jalr + return: the call replaces the entry being consumed
      entries_d[ptr_q] = din;
    end else if (push) begin
      entries_d[ptr_inc] = din;
      ptr_d              = ptr_inc;
      if (!full) count_d = count_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) entries_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: next-PC priority mux, PC/EPC registers and the
// return-address-stack mispredict flag for jr $ra.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int unsigned      RAS_DEPTH  = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             Exception,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [25:0]      JumpIdx,
  input  logic             JumpReg,
  input  logic [WIDTH-1:0] JrTarget,
  input  logic             Link,
  input  logic             Ret,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic [WIDTH-1:0] Epc,
  output logic [WIDTH-1:0] RasTop,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             Mispredict
);

  localparam logic [WIDTH-1:0] ALIGN_MASK  = ~WIDTH'(3);
  // j/jal keep the 256 MB region of the delay-slot PC
  localparam logic [WIDTH-1:0] REGION_MASK = ~WIDTH'(28'hFFF_FFFF);

  npc_sel_e         npc_sel;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             mispredict_q, mispredict_d;
  logic [WIDTH-1:0] br_target, jr_target, j_target;
  logic             ras_push, ras_pop;

  assign PCPlus4    = pc_q + WIDTH'(PC_INCR);
  assign br_target  = BranchTarget & ALIGN_MASK;
  assign jr_target  = JrTarget & ALIGN_MASK;
  assign j_target   = (PCPlus4 & REGION_MASK) | WIDTH'({JumpIdx, 2'b00});
  assign npc_sel    = npc_select(Exception, Stall, JumpReg, Jump, BranchTaken);

  // Link/Ret only count when their jump actually wins the mux
  assign ras_push   = Link && (npc_sel == NPC_J || npc_sel == NPC_JR);
  assign ras_pop    = Ret && (npc_sel == NPC_JR);

  assign PC         = pc_q;
  assign Epc        = epc_q;
  assign Mispredict = mispredict_q;

  pc_ras #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .Clk  (Clk),
    .Rst  (Rst),
    .push (ras_push),
    .pop  (ras_pop),
    .din  (PCPlus4),
    .top  (RasTop),
    .empty(RasEmpty),
    .full (RasFull)
  );

  always_comb begin
    pc_d         = PCPlus4;
    epc_d        = epc_q;
    mispredict_d = 1'b0;
    unique case (npc_sel)
      NPC_EXC: begin
        pc_d  = EXC_VECTOR;
        epc_d = pc_q;
      end
      NPC_HOLD: pc_d = pc_q;
      NPC_JR: begin
        pc_d         = jr_target;
        mispredict_d = ras_pop && (RasEmpty || (RasTop != jr_target));
      end
      NPC_J:   pc_d = j_target;
      NPC_BR:  pc_d = br_target;
      default: pc_d = PCPlus4;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc_q         <= RESET_PC;
      epc_q        <= '0;
      mispredict_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      mispredict_q <= mispredict_d;
    end
  end

endmodule
